lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly downstream of the control decoder.
- Consumes mem_rw, load_sel and store_sel from the decoder, the ALU address and the rs2 data.
- Runs a req/gnt/rvalid handshake with data memory, and returns byte-extended load data to the writeback mux.
- Holds the core with a stall signal until each access completes.

Parameters:
- DW, 32, data and address width (fixed at 32; byte-lane logic assumes 4 lanes).
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before aborting with error; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  Core clock.
- rst_n  in  1  Asynchronous active-low reset.
- req_valid  in  1  Current instruction is a load or store; held stable by the core while stall=1.
- mem_rw  in  1  1=write (store), 0=read (load).
- load_sel  in  3  000=B, 001=H, 010=W, 100=BU, 101=HU; any other value is treated as W.
- store_sel  in  2  00=B, 01=H, 10=W; 11 is treated as W.
- addr  in  32  Byte address from the ALU.
- wdata  in  32  Store data (rs2).
- stall  out  1  Hold PC and pipeline.
- done  out  1  One-cycle completion pulse.
- err  out  1  Misalign or timeout flag; valid only with done.
- rdata  out  32  Extended load data; valid with done, holds until the next done.
- dmem_req  out  1  Memory request.
- dmem_we  out  1  Write enable.
- dmem_addr  out  32  Word address {addr[31:2],2'b00}.
- dmem_be  out  4  Byte enables.
- dmem_wdata  out  32  Lane-aligned write data.
- dmem_gnt  in  1  Request accepted this cycle.
- dmem_rvalid  in  1  Read data valid.
- dmem_rdata  in  32  Read data (full word).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. stall, done, err, dmem_req, dmem_we are 0. rdata, dmem_addr, dmem_be, dmem_wdata are 0. Timeout counter is 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE, req_valid=0: stall=0, stay in IDLE.
- IDLE, req_valid=1: latch mem_rw, the size code, addr[1:0], dmem_addr, dmem_be and the aligned wdata. stall=1.
  - Misaligned → RESP with err_r=1, no memory access. Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - Otherwise → REQ.
- REQ: dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and stable until gnt. stall=1.
  - On dmem_gnt: a store → RESP; a load → WAIT.
- WAIT: dmem_req=0, stall=1. On dmem_rvalid: capture the extended data into rdata → RESP. dmem_rvalid can arrive no earlier than the cycle after gnt.
- RESP: done=1, stall=0, err=err_r → IDLE next cycle. In RESP the core advances its PC; a req_valid seen in RESP is ignored and is re-evaluated in IDLE.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When TIMEOUT≠0 and the count reaches TIMEOUT with no gnt/rvalid in that cycle: dmem_req drops, rdata=0, err_r=1 → RESP.
  - A gnt/rvalid arriving in the same cycle as expiry wins; no error.
- Latency with zero-wait memory:
  - Store: 3 cycles (IDLE, REQ, RESP).
  - Load: 4 cycles (IDLE, REQ, WAIT, RESP).
  - Misaligned: 2 cycles.
- Store lanes, with off=addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Load lanes, using the latched off:
  - B/BU select byte dmem_rdata[8*off+:8], sign- or zero-extended.
  - H/HU select half dmem_rdata[16*off[1]+:16], sign- or zero-extended.
  - W passes the word through.
- Loads drive dmem_be=4'b1111 and dmem_we=0.
- Stray dmem_rvalid in IDLE, REQ or RESP is ignored. A stray dmem_gnt outside REQ is ignored.
- Reset mid-access: abort immediately to IDLE with dmem_req=0. Any later rvalid is ignored.
- rdata is unchanged by stores and misaligned accesses. It is written only on a load capture or a timeout (zero).

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in first REQ cycle → dmem_be=1111, dmem_addr=0x100; done at cycle 3; stall high for 2 cycles; err=0.
- SB addr=0x103, wdata=0x000000A5 → dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
- Loads with dmem_rdata=0x80F17F00 on rvalid one cycle after gnt:
  - LB addr=0x203 → rdata=0xFFFFFF80, done at cycle 4.
  - LBU → rdata=0x00000080.
  - LH addr=0x202 → rdata=0xFFFF80F1.
  - LHU addr=0x200 → rdata=0x00007F00.
- LW addr=0x102 → no dmem_req; done with err=1 at cycle 2; rdata keeps its prior value. LH addr=0x101 gives the same result.
- TIMEOUT=4, gnt held 0 → dmem_req high for 4 cycles then drops; done with err=1 and rdata=0. Repeat with gnt arriving in the 4th cycle → no error.
- Assert rst_n=0 during WAIT → outputs at reset values immediately. An rvalid after reset release produces no done; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the control decoder and data memory. It latches one
// load or store, runs the req/gnt/rvalid handshake, lane-aligns store data,
// byte-extends load data, and stalls the core until the access completes.
module lsu_mem_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          mem_rw,
  input  logic [2:0]    load_sel,
  input  logic [1:0]    store_sel,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Last counter value before expiry; the count clears on entry to REQ.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  state_t          state;
  size_t           size_r;
  logic            uns_r;
  logic [1:0]      off_r;
  logic            err_r;
  logic [TO_W-1:0] to_cnt;

  size_t           req_size;
  logic            req_uns;
  logic            misaligned;
  logic [3:0]      be_nxt;
  logic [DW-1:0]   wdata_nxt;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [DW-1:0]   load_ext;
  logic            timeout_hit;

  // Decode the incoming request: access size, signedness, lanes and alignment.
  // NOTE: every signal gets a default first so no path through the block leaves a latch.
  always_comb begin
    req_size  = SZ_W;
    req_uns   = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    if (mem_rw) begin
      case (store_sel)
        2'b00:   req_size = SZ_B;
        2'b01:   req_size = SZ_H;
        default: req_size = SZ_W;
      endcase
    end else begin
      case (load_sel)
        3'b000:  req_size = SZ_B;
        3'b001:  req_size = SZ_H;
        3'b100:  begin req_size = SZ_B; req_uns = 1'b1; end
        3'b101:  begin req_size = SZ_H; req_uns = 1'b1; end
        default: req_size = SZ_W;
      endcase
    end
    case (req_size)
      SZ_B: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be_nxt    = 4'b0011 << addr[1:0];
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
      end
    endcase
    // Loads always fetch the full word; lane selection happens on return.
    if (!mem_rw) be_nxt = 4'b1111;
    misaligned = ((req_size == SZ_H) && addr[0]) ||
                 ((req_size == SZ_W) && (addr[1:0] != 2'b00));
  end

  // Select and extend the returned lane using the latched offset and size.
  always_comb begin
    byte_sel = dmem_rdata[{off_r, 3'b000} +: 8];
    half_sel = dmem_rdata[{off_r[1], 4'b0000} +: 16];
    case (size_r)
      SZ_B:    load_ext = uns_r ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_ext = uns_r ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  // A handshake arriving in the expiry cycle takes priority over the abort.
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt >= TO_LAST);

  // Access sequencing: latch the request, run the handshake, capture or abort.
  // NOTE: sequential state uses non-blocking assignments so every register reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      rdata      <= '0;
      err_r      <= 1'b0;
      to_cnt     <= '0;
      size_r     <= SZ_W;
      uns_r      <= 1'b0;
      off_r      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dmem_we    <= mem_rw;
            dmem_addr  <= {addr[DW-1:2], 2'b00};
            dmem_be    <= be_nxt;
            dmem_wdata <= wdata_nxt;
            size_r     <= req_size;
            uns_r      <= req_uns;
            off_r      <= addr[1:0];
            err_r      <= misaligned;
            to_cnt     <= '0;
            if (misaligned) begin
              state <= RESP;
            end else begin
              dmem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          to_cnt <= to_cnt + 1'b1;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            state    <= dmem_we ? RESP : WAIT;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            rdata    <= '0;
            err_r    <= 1'b1;
            state    <= RESP;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (dmem_rvalid) begin
            rdata <= load_ext;
            state <= RESP;
          end else if (timeout_hit) begin
            rdata <= '0;
            err_r <= 1'b1;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the request is presented to freeze the PC.
  assign stall = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
  assign done  = (state == RESP);
  assign err   = (state == RESP) && err_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a bench-side model predicts each
// access, the prediction is queued when the request is driven, and it is
// popped and compared when the unit raises done.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_rw;
  logic [2:0]  load_sel;
  logic [1:0]  store_sel;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  lsu_mem_ctrl #(.DW(32), .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_rw(mem_rw),
    .load_sel(load_sel), .store_sel(store_sel), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          reqs;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one access, including the held rdata value.
  task automatic predict(input string tag, input logic rw, input logic [2:0] lsel,
                         input logic [1:0] ssel, input logic [31:0] a, input logic [31:0] wd,
                         input int gnt_dly, input logic [31:0] word, output exp_t e);
    int          sz;
    int          off;
    bit          uns;
    bit          mis;
    logic [31:0] sh;
    off = int'(a[1:0]);
    uns = 1'b0;
    if (rw) begin
      sz = (ssel == 2'b00) ? 0 : (ssel == 2'b01) ? 1 : 2;
    end else begin
      case (lsel)
        3'b000:  sz = 0;
        3'b001:  sz = 1;
        3'b100:  begin sz = 0; uns = 1'b1; end
        3'b101:  begin sz = 1; uns = 1'b1; end
        default: sz = 2;
      endcase
    end
    mis     = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    e.tag   = tag;
    e.we    = rw;
    e.addr  = {a[31:2], 2'b00};
    e.be    = 4'b0000;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (sz == 0) begin
        e.be[i] = (i == off);
        e.wdata[8*i +: 8] = wd[7:0];
      end else if (sz == 1) begin
        e.be[i] = ((i / 2) == (off / 2));
        e.wdata[8*i +: 8] = wd[8*(i%2) +: 8];
      end else begin
        e.be[i] = 1'b1;
        e.wdata[8*i +: 8] = wd[8*i +: 8];
      end
    end
    if (!rw) e.be = 4'b1111;
    e.err = 1'b0;
    if (mis) begin
      e.lat = 2; e.reqs = 0; e.err = 1'b1;
    end else if (gnt_dly == 0 || gnt_dly > TO) begin
      e.lat = TO + 2; e.reqs = TO; e.err = 1'b1;
      model_rdata = '0;
    end else begin
      e.reqs = gnt_dly;
      e.lat  = rw ? gnt_dly + 2 : gnt_dly + 3;
      if (!rw) begin
        if (sz == 0) begin
          sh = word >> (8 * off);
          model_rdata = uns ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
        end else if (sz == 1) begin
          sh = word >> (16 * (off / 2));
          model_rdata = uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
        end else begin
          model_rdata = word;
        end
      end
    end
    e.rdata = model_rdata;
  endtask

  // Drive one access; memory grants on the gnt_dly-th REQ cycle (0 = never)
  // and returns rvalid one cycle after a load grant. Starts and ends on a negedge.
  task automatic access(input string tag, input logic rw, input logic [2:0] lsel,
                        input logic [1:0] ssel, input logic [31:0] a, input logic [31:0] wd,
                        input int gnt_dly, input logic [31:0] word);
    exp_t e;
    exp_t q;
    int   req_cnt;
    int   stall_cnt;
    bit   rv_next;
    bit   finished;
    req_cnt = 0; stall_cnt = 0; rv_next = 1'b0; finished = 1'b0;
    predict(tag, rw, lsel, ssel, a, wd, gnt_dly, word, e);
    sb.push_back(e);
    req_valid = 1'b1; mem_rw = rw; load_sel = lsel; store_sel = ssel; addr = a; wdata = wd;
    for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_F00D;
      if (rv_next) begin
        dmem_rvalid = 1'b1; dmem_rdata = word; rv_next = 1'b0;
      end
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({tag, "_we"}, {31'b0, dmem_we}, {31'b0, e.we});
          check({tag, "_addr"}, dmem_addr, e.addr);
          check({tag, "_be"}, {28'b0, dmem_be}, {28'b0, e.be});
          if (rw) check({tag, "_wdata"}, dmem_wdata, e.wdata);
        end
        if (req_cnt == gnt_dly) begin
          dmem_gnt = 1'b1; rv_next = !rw;
        end
      end
      #1;
      if (done) begin
        finished = 1'b1;
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          q = sb.pop_front();
          check({q.tag, "_latency"}, cyc, q.lat);
          check({q.tag, "_err"}, {31'b0, err}, {31'b0, q.err});
          check({q.tag, "_rdata"}, rdata, q.rdata);
          check({q.tag, "_req_cycles"}, req_cnt, q.reqs);
          check({q.tag, "_stall_cycles"}, stall_cnt, q.lat - 1);
        end
        req_valid = 1'b0;
      end else if (stall) begin
        stall_cnt++;
      end
      @(negedge clk);
    end
    if (!finished) begin
      check({tag, "_done_seen"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      req_valid = 1'b0;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {31'b0, stall}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_req"}, {31'b0, dmem_req}, 32'd0);
    check({tag, "_we"}, {31'b0, dmem_we}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_be"}, {28'b0, dmem_be}, 32'd0);
    check({tag, "_wdata"}, dmem_wdata, 32'd0);
  endtask

  logic [2:0] lsel_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_rw = 1'b0; load_sel = 3'b010; store_sel = 2'b10;
    addr = '0; wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Stores
    access("sw_100", 1'b1, 3'b000, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0);
    access("sb_103", 1'b1, 3'b000, 2'b00, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0);
    access("sh_102", 1'b1, 3'b000, 2'b01, 32'h0000_0102, 32'h1234_5678, 2, 32'h0);
    access("sw_sel3", 1'b1, 3'b000, 2'b11, 32'h0000_0204, 32'hCAFE_F00D, 1, 32'h0);

    // Loads from 0x80F17F00
    access("lb_203", 1'b0, 3'b000, 2'b00, 32'h0000_0203, 32'h0, 1, 32'h80F1_7F00);
    check("lb_203_const", rdata, 32'hFFFF_FF80);
    access("lbu_203", 1'b0, 3'b100, 2'b00, 32'h0000_0203, 32'h0, 1, 32'h80F1_7F00);
    check("lbu_203_const", rdata, 32'h0000_0080);
    access("lh_202", 1'b0, 3'b001, 2'b00, 32'h0000_0202, 32'h0, 1, 32'h80F1_7F00);
    check("lh_202_const", rdata, 32'hFFFF_80F1);
    access("lhu_200", 1'b0, 3'b101, 2'b00, 32'h0000_0200, 32'h0, 1, 32'h80F1_7F00);
    check("lhu_200_const", rdata, 32'h0000_7F00);

    // Misaligned accesses leave rdata alone and never touch memory
    access("lw_102_mis", 1'b0, 3'b010, 2'b00, 32'h0000_0102, 32'h0, 1, 32'h1111_1111);
    check("lw_102_hold", rdata, 32'h0000_7F00);
    access("lh_101_mis", 1'b0, 3'b001, 2'b00, 32'h0000_0101, 32'h0, 1, 32'h2222_2222);
    access("sw_101_mis", 1'b1, 3'b000, 2'b10, 32'h0000_0101, 32'h3333_3333, 1, 32'h0);

    // Mixed loads with random data, offsets and grant delay
    for (int i = 0; i < 8; i++) begin
      access($sformatf("rnd_ld%0d", i), 1'b0, lsel_tab[i % 6], 2'b00,
             32'h0000_0400 + 32'($urandom_range(0, 3)), 32'h0,
             int'($urandom_range(1, 2)), $urandom);
    end

    // Reset during WAIT aborts at once; later rvalid and stray gnt do nothing
    req_valid = 1'b1; mem_rw = 1'b0; load_sel = 3'b010; addr = 32'h0000_0300;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("rst_pre_wait_stall", {31'b0, stall}, 32'd1);
    check("rst_pre_wait_req", {31'b0, dmem_req}, 32'd0);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #1;
    check("stray_rv_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
    #1;
    check("stray_rv_done", {31'b0, done}, 32'd0);
    check("stray_rv_rdata", rdata, 32'd0);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("stray_gnt_req", {31'b0, dmem_req}, 32'd0);
    check("stray_gnt_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    access("lw_after_rst", 1'b0, 3'b010, 2'b00, 32'h0000_0300, 32'h0, 1, 32'h5A5A_1234);

    // Timeouts: no grant aborts with rdata cleared; grant in the last cycle wins
    access("lw_timeout", 1'b0, 3'b010, 2'b00, 32'h0000_0500, 32'h0, 0, 32'h0);
    check("lw_timeout_rdata", rdata, 32'd0);
    access("ld_refill", 1'b0, 3'b010, 2'b00, 32'h0000_0504, 32'h0, 1, 32'h0F0F_0F0F);
    access("sw_timeout", 1'b1, 3'b000, 2'b10, 32'h0000_0600, 32'hAAAA_5555, 0, 32'h0);
    access("sw_gnt_last", 1'b1, 3'b000, 2'b10, 32'h0000_0604, 32'h5555_AAAA, TO, 32'h0);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
